// File: rtl/prbs_checker_pkg.sv
// -----------------------------------------------------------------------------
// prbs_checker_pkg
// Shared definitions for the PRBS checker and its feedback helper:
//   - default parameter values (LFSR length, lock/loss thresholds, widths)
//   - checker state encodings (FILL, SEARCH, LOCKED)
// -----------------------------------------------------------------------------
package prbs_checker_pkg;

  // Default parameter values, shared by the checker and its sub-module
  localparam int DEF_BIT_WIDTH   = 8;
  localparam int DEF_LOCK_COUNT  = 16;
  localparam int DEF_WINDOW      = 64;
  localparam int DEF_LOSS_THRESH = 8;
  localparam int DEF_CNT_WIDTH   = 16;

  // Checker state encoding
  localparam logic [1:0] ST_FILL   = 2'd0;
  localparam logic [1:0] ST_SEARCH = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage : prbs_checker_pkg

// File: rtl/prbs_feedback.sv
// -----------------------------------------------------------------------------
// prbs_feedback
// Combinational LFSR feedback term, shared by the PRBS generator and checker.
// Given the history (hist_i[0] = newest bit) it returns the next bit:
//   hist[W-1] ^ hist[W-3] ^ ~hist[W-5]
// The inverted tap keeps the all-zero history from being a lock-up state.
// Ports:
//   hist_i : BIT_WIDTH-bit history register
//   fb_o   : predicted next bit
// -----------------------------------------------------------------------------
module prbs_feedback
  import prbs_checker_pkg::*;
#(
  parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
  input  logic [BIT_WIDTH-1:0] hist_i,
  output logic                 fb_o
);

  assign fb_o = hist_i[BIT_WIDTH-1] ^ hist_i[BIT_WIDTH-3] ^ ~hist_i[BIT_WIDTH-5];

endmodule : prbs_feedback

// File: rtl/prbs_checker.sv
// -----------------------------------------------------------------------------
// prbs_checker
// Self-synchronising PRBS receiver check. Fills a history register from the
// incoming stream, searches for LOCK_COUNT consecutive correct predictions,
// then runs locked: the history follows its own predictions so each corrupted
// input bit is counted exactly once. Too many errors inside one monitoring
// window drops lock and restarts the fill.
// Ports:
//   clk          : clock, rising edge
//   reset        : asynchronous active-high reset
//   data_in      : received PRBS bit
//   data_valid   : qualifies data_in; all state holds while low
//   clear_counts : synchronous clear of error_count (wins over an increment)
//   locked       : high while in LOCKED
//   error_pulse  : one-cycle pulse per counted bit error
//   error_count  : saturating count of errors seen while locked
// -----------------------------------------------------------------------------
module prbs_checker
  import prbs_checker_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int LOCK_COUNT  = DEF_LOCK_COUNT,
  parameter int WINDOW      = DEF_WINDOW,
  parameter int LOSS_THRESH = DEF_LOSS_THRESH,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 data_in,
  input  logic                 data_valid,
  input  logic                 clear_counts,
  output logic                 locked,
  output logic                 error_pulse,
  output logic [CNT_WIDTH-1:0] error_count
);

  localparam int FILL_W = $clog2(BIT_WIDTH + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);

  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(BIT_WIDTH - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [WERR_W-1:0] WERR_LOSS = WERR_W'(LOSS_THRESH);

  logic [1:0]           state_q,   state_d;
  logic [BIT_WIDTH-1:0] hist_q,    hist_d;
  logic [FILL_W-1:0]    fill_q,    fill_d;
  logic [GOOD_W-1:0]    good_q,    good_d;
  logic [WIN_W-1:0]     win_q,     win_d;
  logic [WERR_W-1:0]    werr_q,    werr_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                 pulse_q,   pulse_d;
  logic                 locked_q,  locked_d;

  logic                 pred_s;
  logic                 err_s;
  logic [WERR_W-1:0]    werr_inc_s;

  prbs_feedback #(.BIT_WIDTH(BIT_WIDTH)) u_feedback (
    .hist_i (hist_q),
    .fb_o   (pred_s)
  );

  assign werr_inc_s = werr_q + WERR_W'(err_s);

  // Next-state logic: fill / search / locked tracking and error accounting
  always_comb begin
    state_d  = state_q;
    hist_d   = hist_q;
    fill_d   = fill_q;
    good_d   = good_q;
    win_d    = win_q;
    werr_d   = werr_q;
    err_s    = 1'b0;
    if (data_valid) begin
      case (state_q)
        ST_FILL: begin
          hist_d = {hist_q[BIT_WIDTH-2:0], data_in};
          if (fill_q == FILL_LAST) begin
            fill_d  = '0;
            good_d  = '0;
            state_d = ST_SEARCH;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
        ST_SEARCH: begin
          // Shift the received bit so the history resynchronises to the stream
          hist_d = {hist_q[BIT_WIDTH-2:0], data_in};
          if (data_in == pred_s) begin
            if (good_q == GOOD_LAST) begin
              good_d  = '0;
              win_d   = '0;
              werr_d  = '0;
              state_d = ST_LOCKED;
            end else begin
              good_d = good_q + 1'b1;
            end
          end else begin
            good_d = '0;
          end
        end
        ST_LOCKED: begin
          // Follow the prediction: a corrupted bit never enters the history
          hist_d = {hist_q[BIT_WIDTH-2:0], pred_s};
          err_s  = (data_in != pred_s);
          if (err_s && (werr_inc_s == WERR_LOSS)) begin
            state_d = ST_FILL;
            fill_d  = '0;
            good_d  = '0;
            win_d   = '0;
            werr_d  = '0;
          end else if (win_q == WIN_LAST) begin
            win_d  = '0;
            werr_d = '0;
          end else begin
            win_d  = win_q + 1'b1;
            werr_d = werr_inc_s;
          end
        end
        default: begin
          state_d = ST_FILL;
          fill_d  = '0;
          good_d  = '0;
          win_d   = '0;
          werr_d  = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    pulse_d  = err_s;
    locked_d = (state_d == ST_LOCKED);

    if (clear_counts) begin
      err_cnt_d = '0;
    end else if (err_s && (err_cnt_q != {CNT_WIDTH{1'b1}})) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FILL;
      hist_q    <= '0;
      fill_q    <= '0;
      good_q    <= '0;
      win_q     <= '0;
      werr_q    <= '0;
      err_cnt_q <= '0;
      pulse_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      good_q    <= good_d;
      win_q     <= win_d;
      werr_q    <= werr_d;
      err_cnt_q <= err_cnt_d;
      pulse_q   <= pulse_d;
      locked_q  <= locked_d;
    end
  end

  assign locked      = locked_q;
  assign error_pulse = pulse_q;
  assign error_count = err_cnt_q;

endmodule : prbs_checker

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        din1, dv1, clr1, lk1, ep1;
  logic [15:0] ec1;
  logic        din2, dv2, clr2, lk2, ep2;
  logic [3:0]  ec2;

  prbs_checker dut1 (
    .clk(clk), .reset(reset), .data_in(din1), .data_valid(dv1),
    .clear_counts(clr1), .locked(lk1), .error_pulse(ep1), .error_count(ec1)
  );

  prbs_checker #(.CNT_WIDTH(4), .LOSS_THRESH(64)) dut2 (
    .clk(clk), .reset(reset), .data_in(din2), .data_valid(dv2),
    .clear_counts(clr2), .locked(lk2), .error_pulse(ep2), .error_count(ec2)
  );

  typedef struct {
    bit which;
    bit lk;
    bit pl;
    int ct;
  } exp_t;

  exp_t       q[$];
  exp_t       m_e;
  int         total = 0;
  int         bad = 0;
  logic [7:0] gen = 8'hA5;
  int         lk_bits = 0;
  bit         in_lock = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d required %0d (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // One stimulus cycle: drive a bit (optionally corrupted) and queue the
  // response expected after the next rising edge.
  task automatic step(input bit which, input bit valid, input bit err, input bit clr,
                      input bit e_lk, input bit e_pl, input int e_ct);
    logic nb;
    exp_t e;
    @(negedge clk);
    if (valid) begin
      nb  = gen[7] ^ gen[5] ^ ~gen[3];
      gen = {gen[6:0], nb};
      if (in_lock) lk_bits++;
    end else begin
      nb = ~gen[0];
    end
    if (!which) begin
      din1 = nb ^ err; dv1 = valid; clr1 = clr; dv2 = 1'b0; clr2 = 1'b0;
    end else begin
      din2 = nb ^ err; dv2 = valid; clr2 = clr; dv1 = 1'b0; clr1 = 1'b0;
    end
    e.which = which; e.lk = e_lk; e.pl = e_pl; e.ct = e_ct;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    dv1 = 1'b0; dv2 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: %0d entries left, required 0", q.size());
      q.delete();
    end
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      if (!m_e.which) begin
        check("locked", 32'(lk1), 32'(m_e.lk));
        check("error_pulse", 32'(ep1), 32'(m_e.pl));
        check("error_count", 32'(ec1), m_e.ct);
      end else begin
        check("sat_locked", 32'(lk2), 32'(m_e.lk));
        check("sat_error_pulse", 32'(ep2), 32'(m_e.pl));
        check("sat_error_count", 32'(ec2), m_e.ct);
      end
    end
  end

  initial begin
    reset = 1'b1;
    din1 = 1'b0; dv1 = 1'b0; clr1 = 1'b0;
    din2 = 1'b0; dv2 = 1'b0; clr2 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_locked", 32'(lk1), 32'd0);
    check("reset_count", 32'(ec1), 32'd0);
    check("reset_pulse", 32'(ep1), 32'd0);
    reset = 1'b0;

    // Acquisition: 8 fill bits + 16 matches, locked after the 24th bit
    for (int i = 1; i <= 24; i++) step(1'b0, 1'b1, 1'b0, 1'b0, (i == 24), 1'b0, 0);
    in_lock = 1'b1; lk_bits = 0;
    for (int i = 0; i < 976; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Single corrupted bit: one pulse, count 1, lock held
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1);

    // Clear coinciding with an error: count cleared, pulse still seen
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // data_valid low for 5 cycles with garbage data: nothing changes
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);

    // Align to a window start, then 8 consecutive errors drop lock
    while ((lk_bits % 64) != 0) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 1'b1, 1'b0, (k < 8), 1'b1, k);
    in_lock = 1'b0;
    for (int i = 1; i <= 24; i++) step(1'b0, 1'b1, 1'b0, 1'b0, (i == 24), 1'b0, 8);
    in_lock = 1'b1; lk_bits = 0;

    // Build error_count = 3, then async reset mid-cycle
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, k);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, k);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, k);
    end
    drain();
    check("pre_reset_count", 32'(ec1), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("async_reset_locked", 32'(lk1), 32'd0);
    check("async_reset_count", 32'(ec1), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    in_lock = 1'b0;

    // Narrow counter: 20 isolated errors saturate at 15
    for (int i = 1; i <= 24; i++) step(1'b1, 1'b1, 1'b0, 1'b0, (i == 24), 1'b0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, (k > 15) ? 15 : k);
      for (int j = 0; j < 3; j++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, (k > 15) ? 15 : k);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prbs_checker
